// File: rtl/csa_pipe_adder_pkg.sv
// Shared types and sizing helpers for the pipelined carry-select adder.
package csa_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int csa_blocks(int word_width, int block_width);
    return word_width / block_width;
  endfunction

  // Rounded up, so the last stage may end up holding fewer blocks (or none).
  function automatic int csa_blocks_per_stage(int blocks, int stages);
    return (blocks + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/csa_pipe_adder_block.sv
// One carry-select block: both carry-in cases are summed up front and the real
// carry only drives the final mux.
module csa_block #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] sum0;
  logic [WIDTH:0] sum1;

  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(1);
  assign {cout, sum} = cin ? sum1 : sum0;

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Optional zero/overflow flags are enabled with CSA_PIPE_FLAGS_EN.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 4,
  parameter int STAGES      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  op_i,
  input  logic                  c_i,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] r_o,
  output logic                  c_o
`ifdef CSA_PIPE_FLAGS_EN
  ,
  output logic                  z_o,
  output logic                  v_o
`endif
);

  localparam int BLOCKS = csa_blocks(WORD_WIDTH, BLOCK_WIDTH);
  localparam int BPS    = csa_blocks_per_stage(BLOCKS, STAGES);
  localparam int LAST   = STAGES - 1;

  if (WORD_WIDTH % BLOCK_WIDTH != 0) begin : g_bad_width
    $error("csa_pipe_adder: WORD_WIDTH must be a multiple of BLOCK_WIDTH");
  end
  if (STAGES < 1 || STAGES > BLOCKS) begin : g_bad_stages
    $error("csa_pipe_adder: STAGES must lie in 1..WORD_WIDTH/BLOCK_WIDTH");
  end

  op_e  op;
  logic sub;

  assign op  = op_e'(op_i);
  assign sub = (op == OP_SUB);

  logic [WORD_WIDTH-1:0] in_a  [STAGES];
  logic [WORD_WIDTH-1:0] in_b  [STAGES];
  logic [WORD_WIDTH-1:0] in_r  [STAGES];
  logic                  in_c  [STAGES];
  logic                  in_v  [STAGES];
  logic [WORD_WIDTH-1:0] out_r [STAGES];
  logic                  out_c [STAGES];
  logic [WORD_WIDTH-1:0] reg_a [STAGES];
  logic [WORD_WIDTH-1:0] reg_b [STAGES];
  logic [WORD_WIDTH-1:0] reg_r [STAGES];
  logic                  reg_c [STAGES];
  logic                  reg_v [STAGES];
  logic                  load  [STAGES];

  logic [WORD_WIDTH-1:0] blk_sum;
  logic [BLOCKS-1:0]     blk_cout;

  // Subtraction is folded in here: B is inverted and the borrow-in becomes an
  // inverted carry, so every later stage is a plain adder.
  always_comb begin
    in_a[0] = a_i;
    in_b[0] = sub ? ~b_i : b_i;
    in_r[0] = '0;
    in_c[0] = sub ? ~c_i : c_i;
    in_v[0] = valid_i;
    for (int s = 1; s < STAGES; s++) begin
      in_a[s] = reg_a[s-1];
      in_b[s] = reg_b[s-1];
      in_r[s] = reg_r[s-1];
      in_c[s] = reg_c[s-1];
      in_v[s] = reg_v[s-1];
    end
  end

  // A stage may load when empty or when its current item moves on; evaluated
  // from the output end so ready_i ripples back to ready_o in the same cycle.
  always_comb begin
    for (int s = LAST; s >= 0; s--) begin
      if (s == LAST) begin
        load[s] = !reg_v[s] || ready_i;
      end else begin
        load[s] = !reg_v[s] || load[s+1];
      end
    end
  end

  for (genvar j = 0; j < BLOCKS; j++) begin : g_blk
    localparam int S = j / BPS;
    logic                   cin;
    logic                   cout;
    logic [BLOCK_WIDTH-1:0] sum;

    if (j % BPS == 0) begin : g_head
      assign cin = in_c[S];
    end else begin : g_link
      assign cin = g_blk[j-1].cout;
    end

    csa_block #(.WIDTH(BLOCK_WIDTH)) u_block (
      .a    (in_a[S][j*BLOCK_WIDTH +: BLOCK_WIDTH]),
      .b    (in_b[S][j*BLOCK_WIDTH +: BLOCK_WIDTH]),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
    );

    assign blk_sum[j*BLOCK_WIDTH +: BLOCK_WIDTH] = sum;
    assign blk_cout[j] = cout;
  end

  // Stages without blocks of their own simply pass result and carry along.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      out_r[s] = in_r[s];
      out_c[s] = in_c[s];
    end
    for (int j = 0; j < BLOCKS; j++) begin
      out_r[j/BPS][j*BLOCK_WIDTH +: BLOCK_WIDTH] = blk_sum[j*BLOCK_WIDTH +: BLOCK_WIDTH];
      out_c[j/BPS] = blk_cout[j];
    end
  end

  // Data registers only load with a valid item, so the output holds its last
  // delivered value while the pipe runs empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        reg_v[s] <= 1'b0;
        reg_a[s] <= '0;
        reg_b[s] <= '0;
        reg_r[s] <= '0;
        reg_c[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (load[s]) begin
          reg_v[s] <= in_v[s];
          if (in_v[s]) begin
            reg_a[s] <= in_a[s];
            reg_b[s] <= in_b[s];
            reg_r[s] <= out_r[s];
            reg_c[s] <= out_c[s];
          end
        end
      end
    end
  end

  assign ready_o = load[0];
  assign valid_o = reg_v[LAST];
  assign r_o     = reg_r[LAST];
  assign c_o     = reg_c[LAST];

`ifdef CSA_PIPE_FLAGS_EN
  logic z_q;
  logic v_q;
  logic z_next;
  logic v_next;

  // B is already inverted for SUB, so one same-sign test covers both ops.
  assign z_next = (out_r[LAST] == '0);
  assign v_next = (in_a[LAST][WORD_WIDTH-1] == in_b[LAST][WORD_WIDTH-1]) &&
                  (out_r[LAST][WORD_WIDTH-1] != in_a[LAST][WORD_WIDTH-1]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      z_q <= 1'b0;
      v_q <= 1'b0;
    end else if (load[LAST] && in_v[LAST]) begin
      z_q <= z_next;
      v_q <= v_next;
    end
  end

  assign z_o = z_q;
  assign v_o = v_q;
`endif

endmodule
